// File: rtl/if_fetch_ctrl.sv
// MiniMIPS32 instruction-fetch front end.
// Owns the PC, the imem req/ack port and the IF/ID register.
module if_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              stall_i,
    input  logic [1:0]        jtsel,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [31:0]       id_inst_o,
    output logic              id_valid_o
);

    typedef enum logic {
        S_FETCH,
        S_HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_r;
    logic              redir_pend;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] buf_pc;
    logic [31:0]       buf_inst;

    logic              redirect_now;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    logic              ifid_word;
    logic              ifid_bubble;
    logic              ifid_buf;
    logic              buf_load;
    logic              pc_load;
    logic              pc_redir;
    logic              pend_set;

    // The branch in IF/ID only counts when it actually advances to EX.
    assign redirect_now = id_valid_o && !stall_i && (jtsel != 2'b00);
    assign imem_addr    = pc_r;

    // Decode's target select.
    always_comb begin
        target = '0;
        case (jtsel)
            2'b01:   target = addr3;
            2'b10:   target = addr1;
            2'b11:   target = addr2;
            default: target = '0;
        endcase
    end

    // PC after the word at pc_r completes; a live redirect beats a parked one.
    always_comb begin
        next_pc = pc_r + ADDR_W'(4);
        if (redirect_now) begin
            next_pc = target;
        end else if (redir_pend) begin
            next_pc = redir_tgt;
        end
    end

    // Next state plus the per-cycle datapath controls.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ifid_word   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_buf    = 1'b0;
        buf_load    = 1'b0;
        pc_load     = 1'b0;
        pc_redir    = 1'b0;
        pend_set    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = cpu_rst_n;
                if (imem_ack) begin
                    pc_load = 1'b1;
                    if (stall_i) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        ifid_word = 1'b1;
                    end
                end else begin
                    ifid_bubble = !stall_i;
                    pend_set    = redirect_now;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    ifid_buf = 1'b1;
                    pc_redir = redirect_now;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and parked redirect; the delay slot always completes first.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_r       <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
        end else begin
            if (pc_load) begin
                pc_r       <= next_pc;
                redir_pend <= 1'b0;
            end else if (pc_redir) begin
                pc_r <= target;
            end
            if (pend_set) begin
                redir_pend <= 1'b1;
                redir_tgt  <= target;
            end
        end
    end

    // One-word skid buffer for a word that lands while decode is stalled.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            buf_pc   <= '0;
            buf_inst <= '0;
        end else if (buf_load) begin
            buf_pc   <= pc_r;
            buf_inst <= imem_rdata;
        end
    end

    // IF/ID register: fresh word, buffered word, bubble, or hold.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
        end else if (ifid_word) begin
            id_pc_o    <= pc_r;
            id_inst_o  <= imem_rdata;
            id_valid_o <= 1'b1;
        end else if (ifid_buf) begin
            id_pc_o    <= buf_pc;
            id_inst_o  <= buf_inst;
            id_valid_o <= 1'b1;
        end else if (ifid_bubble) begin
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl.
// Memory model with per-address latency, small decode model, IF/ID scoreboard.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  jtsel;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] addr3;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 0;
    int          wcnt;
    int          bad_hits = 0;
    logic        mon_ld;
    logic [31:0] mon_exp;

    logic [31:0] br_pc  [4] = '{32'h20, 32'h104, 32'h40, 32'h204};
    logic [1:0]  br_sel [4] = '{2'b11, 2'b10, 2'b01, 2'b10};
    logic [31:0] br_tgt [4] = '{32'h100, 32'h40, 32'h200, 32'h30};

    if_fetch_ctrl #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n  (rst_n),
        .stall_i    (stall),
        .jtsel      (jtsel),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst),
        .id_valid_o (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb begin
        imem_ack = imem_req &&
                   (wcnt >= ((imem_addr == slow_addr) ? slow_lat : 0));
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always_comb begin
        jtsel = 2'b00;
        addr1 = 32'hBAD0_0001;
        addr2 = 32'hBAD0_0002;
        addr3 = 32'hBAD0_0003;
        for (int i = 0; i < 4; i++) begin
            if (id_valid && id_pc == br_pc[i]) begin
                jtsel = br_sel[i];
                case (br_sel[i])
                    2'b01:   addr3 = br_tgt[i];
                    2'b10:   addr1 = br_tgt[i];
                    default: addr2 = br_tgt[i];
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (imem_req && (imem_addr inside {32'h28, 32'h48, 32'h10C, 32'h20C}))
            bad_hits++;
    end

    always @(posedge clk) begin
        mon_ld = rst_n && !stall;
        #1;
        if (mon_ld && id_valid) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_extra: got pc %h expected none", id_pc);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                vectors++;
                assert (id_pc === mon_exp) else begin
                    miscompares++;
                    $error("FAIL sb_pc: got %h expected %h", id_pc, mon_exp);
                end
                vectors++;
                assert (id_inst === mem_word(mon_exp)) else begin
                    miscompares++;
                    $error("FAIL sb_inst: got %h expected %h",
                           id_inst, mem_word(mon_exp));
                end
            end
        end else if (mon_ld) begin
            vectors++;
            assert (id_pc === 32'h0 && id_inst === 32'h0) else begin
                miscompares++;
                $error("FAIL bubble: got %h/%h expected 0/0", id_pc, id_inst);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < 300) else begin
            miscompares++;
            $error("FAIL wait_addr: got %h expected %h", imem_addr, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        slow_addr = 32'h8;
        slow_lat  = 3;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
                  32'h1C, 32'h20, 32'h24, 32'h100, 32'h104, 32'h108,
                  32'h40, 32'h44, 32'h200, 32'h204, 32'h208};
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("start_req", {31'b0, imem_req}, 32'h1);
        chk("start_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("seq_addr4", imem_addr, 32'h4);
        @(negedge clk);
        chk("seq_addr8", imem_addr, 32'h8);

        wait_addr(32'h8);
        for (int i = 0; i < 4; i++) begin
            chk("slow_hold", imem_addr, 32'h8);
            if (i > 0) begin
                chk("slow_bub_v", {31'b0, id_valid}, 32'h0);
                chk("slow_bub_i", id_inst, 32'h0);
            end
            @(negedge clk);
        end
        chk("slow_next", imem_addr, 32'hC);
        slow_addr = 32'h44;
        slow_lat  = 2;

        wait_addr(32'h10);
        stall = 1'b1;
        @(negedge clk);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_pc", id_pc, 32'hC);
        @(negedge clk);
        chk("hold_req2", {31'b0, imem_req}, 32'h0);
        chk("hold_pc2", id_pc, 32'hC);
        chk("hold_v2", {31'b0, id_valid}, 32'h1);
        stall = 1'b0;
        @(negedge clk);
        chk("rel_pc", id_pc, 32'h10);
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h14);
        @(negedge clk);
        chk("rel_next", imem_addr, 32'h18);

        wait_addr(32'h44);
        chk("jr_id", id_pc, 32'h40);
        @(negedge clk);
        chk("jr_bub", {31'b0, id_valid}, 32'h0);
        chk("jr_hold", imem_addr, 32'h44);
        @(negedge clk);
        chk("jr_hold2", imem_addr, 32'h44);
        @(negedge clk);
        chk("jr_tgt", imem_addr, 32'h200);
        chk("jr_ds", id_pc, 32'h44);
        slow_addr = 32'h30;
        slow_lat  = 1000;

        wait_addr(32'h30);
        @(negedge clk);
        @(negedge clk);
        chk("pend_addr", imem_addr, 32'h30);
        chk("pend_req", {31'b0, imem_req}, 32'h1);
        chk("q_drained", 32'(exp_q.size()), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        chk("mid_rst_v", {31'b0, id_valid}, 32'h0);
        chk("mid_rst_pc", id_pc, 32'h0);
        chk("mid_rst_inst", id_inst, 32'h0);
        slow_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        rst_n = 1'b1;
        #1;
        chk("restart_req", {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        wait_addr(32'h14);
        chk("q_final", 32'(exp_q.size()), 32'h0);
        chk("bad_addr", 32'(bad_hits), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
